// File: rtl/axi_pkg.sv
// Shared AXI read/write responder types: response codes, FSM states and
// the per-cycle event bundle the responder decodes.
package axi_pkg;

  localparam int unsigned RESP_W = 2;

  localparam logic [RESP_W-1:0] RRESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RRESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RRESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEMRD = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Per-cycle events seen by the responder FSM.
  typedef struct packed {
    logic ar_hs;     // AR handshake this edge
    logic in_range;  // presented address is implemented
    logic data_hit;  // memory data returned while waiting
    logic timeout;   // last permitted wait cycle
  } hook_t;

endpackage

// File: rtl/axi_read_responder_if.sv
// AR/R channel plus the simple memory read port, grouped for the responder.
interface axi_read_responder_if #(
  parameter int unsigned LEN_ADDR = 10,
  parameter int unsigned LEN_DATA = 32
);
  logic                ARVALID;
  logic                ARREADY;
  logic [LEN_ADDR-1:0] ARADDR;
  logic                RVALID;
  logic                RREADY;
  logic [LEN_DATA-1:0] RDATA;
  logic [1:0]          RRESP;
  logic                MEM_RE;
  logic [LEN_ADDR-1:0] MEM_ADDR;
  logic [LEN_DATA-1:0] MEM_RDATA;
  logic                MEM_RVALID;

  modport slave (
    input  ARVALID, ARADDR, RREADY, MEM_RDATA, MEM_RVALID,
    output ARREADY, RVALID, RDATA, RRESP, MEM_RE, MEM_ADDR
  );

  modport master (
    output ARVALID, ARADDR, RREADY, MEM_RDATA, MEM_RVALID,
    input  ARREADY, RVALID, RDATA, RRESP, MEM_RE, MEM_ADDR
  );
endinterface

// File: rtl/r_rsp_reg.sv
// Response-channel output register: a loaded beat holds valid/data/resp
// until the master accepts it.
module r_rsp_reg
  import axi_pkg::*;
#(
  parameter int unsigned LEN_DATA = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [LEN_DATA-1:0] data_i,
  input  logic [RESP_W-1:0]   resp_i,
  input  logic                rready_i,
  output logic                rvalid_o,
  output logic [LEN_DATA-1:0] rdata_o,
  output logic [RESP_W-1:0]   rresp_o
);

  logic                rvalid_q, rvalid_d;
  logic [LEN_DATA-1:0] rdata_q,  rdata_d;
  logic [RESP_W-1:0]   rresp_q,  rresp_d;

  // Data and response only change on load, so they are stable while stalled.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && rready_i) begin
      rvalid_d = 1'b0;
    end
    if (load_i) begin
      rvalid_d = 1'b1;
      rdata_d  = data_i;
      rresp_d  = resp_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RRESP_OKAY;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign rresp_o  = rresp_q;

endmodule

// File: rtl/axi_read_responder.sv
// Single-outstanding AXI read responder: decodes the word address, reads a
// latency-variable memory with a bounded wait, and returns one R beat.
module axi_read_responder
  import axi_pkg::*;
#(
  parameter int unsigned LEN_ADDR  = 10,
  parameter int unsigned LEN_DATA  = 32,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  axi_read_responder_if.slave  bus,
  output logic                 BUSY
);

  localparam int unsigned CNT_MIN = 5;
  localparam int unsigned CNT_REQ = $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_W   = (CNT_REQ > CNT_MIN) ? CNT_REQ : CNT_MIN;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LEN_ADDR-1:0] addr_q, addr_d;
  logic                mem_re_q, mem_re_d;
  logic                arready_q, arready_d;
  logic                busy_q, busy_d;

  hook_t               hook_c;
  logic                r_hs_c;
  logic                load_c;
  logic [LEN_DATA-1:0] ldata_c;
  logic [RESP_W-1:0]   lresp_c;

  logic                rvalid_w;
  logic [LEN_DATA-1:0] rdata_w;
  logic [RESP_W-1:0]   rresp_w;

  always_comb begin
    hook_c          = '0;
    hook_c.ar_hs    = (state_q == IDLE) && bus.ARVALID && arready_q;
    hook_c.in_range = (32'(bus.ARADDR) < MEM_WORDS);
    hook_c.data_hit = (state_q == MEMRD) && bus.MEM_RVALID;
    hook_c.timeout  = (state_q == MEMRD) && (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  assign r_hs_c = rvalid_w && bus.RREADY;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hook_c.ar_hs) state_d = hook_c.in_range ? MEMRD : RESP;
      MEMRD:   if (hook_c.data_hit || hook_c.timeout) state_d = RESP;
      RESP:    if (r_hs_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Data wins over timeout when both land on the same edge.
  always_comb begin
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    mem_re_d  = 1'b0;
    arready_d = (state_d == IDLE);
    busy_d    = (state_d != IDLE);
    load_c    = 1'b0;
    ldata_c   = '0;
    lresp_c   = RRESP_OKAY;
    unique case (state_q)
      IDLE: begin
        if (hook_c.ar_hs) begin
          addr_d   = bus.ARADDR;
          cnt_d    = '0;
          mem_re_d = hook_c.in_range;
          if (!hook_c.in_range) begin
            load_c  = 1'b1;
            lresp_c = RRESP_DECERR;
          end
        end
      end
      MEMRD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (hook_c.data_hit) begin
          load_c  = 1'b1;
          ldata_c = bus.MEM_RDATA;
          lresp_c = RRESP_OKAY;
        end else if (hook_c.timeout) begin
          load_c  = 1'b1;
          lresp_c = RRESP_SLVERR;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cnt_q     <= '0;
      addr_q    <= '0;
      mem_re_q  <= 1'b0;
      arready_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      mem_re_q  <= mem_re_d;
      arready_q <= arready_d;
      busy_q    <= busy_d;
    end
  end

  r_rsp_reg #(
    .LEN_DATA (LEN_DATA)
  ) u_r_rsp_reg (
    .clk      (ACLK),
    .rst_n    (ARESETn),
    .load_i   (load_c),
    .data_i   (ldata_c),
    .resp_i   (lresp_c),
    .rready_i (bus.RREADY),
    .rvalid_o (rvalid_w),
    .rdata_o  (rdata_w),
    .rresp_o  (rresp_w)
  );

  assign bus.ARREADY  = arready_q;
  assign bus.MEM_RE   = mem_re_q;
  assign bus.MEM_ADDR = addr_q;
  assign bus.RVALID   = rvalid_w;
  assign bus.RDATA    = rdata_w;
  assign bus.RRESP    = rresp_w;
  assign BUSY         = busy_q;

endmodule

// File: tb/tb_axi_read_responder.sv
// Directed bench for axi_read_responder: hit, decode error, timeout,
// back-pressure, mid-transaction reset and data-on-timeout-edge.
module tb_axi_read_responder;

  localparam int unsigned LEN_ADDR  = 10;
  localparam int unsigned LEN_DATA  = 32;
  localparam int unsigned MEM_WORDS = 1000;
  localparam int unsigned TIMEOUT   = 16;

  logic ACLK;
  logic ARESETn;
  logic BUSY;

  axi_read_responder_if #(.LEN_ADDR(LEN_ADDR), .LEN_DATA(LEN_DATA)) bus ();

  axi_read_responder #(
    .LEN_ADDR  (LEN_ADDR),
    .LEN_DATA  (LEN_DATA),
    .MEM_WORDS (MEM_WORDS),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus),
    .BUSY    (BUSY)
  );

  logic [31:0] mem [0:1023];
  int n_checks = 0;
  int n_errors = 0;
  int re_count = 0;
  int re_before;
  logic seen_rvalid;

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) begin
    if (bus.MEM_RE) re_count <= re_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic ar_issue(input logic [LEN_ADDR-1:0] addr);
    bus.ARVALID = 1'b1;
    bus.ARADDR  = addr;
    tick();
    bus.ARVALID = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
    mem[5] = 32'hDEADBEEF;
    mem[3] = 32'h0BADF00D;
    mem[7] = 32'h12345678;

    ARESETn        = 1'b0;
    bus.ARVALID    = 1'b0;
    bus.ARADDR     = '0;
    bus.RREADY     = 1'b1;
    bus.MEM_RVALID = 1'b0;
    bus.MEM_RDATA  = '0;

    // Reset values
    #12;
    check("rst_arready", 32'(bus.ARREADY), 32'd0);
    check("rst_rvalid",  32'(bus.RVALID),  32'd0);
    check("rst_mem_re",  32'(bus.MEM_RE),  32'd0);
    check("rst_busy",    32'(BUSY),        32'd0);
    check("rst_rdata",   32'(bus.RDATA),   32'd0);
    check("rst_rresp",   32'(bus.RRESP),   32'd0);
    check("rst_mem_addr", 32'(bus.MEM_ADDR), 32'd0);
    @(posedge ACLK);
    #3 ARESETn = 1'b1;
    tick();
    check("rel_arready", 32'(bus.ARREADY), 32'd1);

    // Scenario 1: zero-latency hit
    re_before = re_count;
    ar_issue(10'd5);
    check("s1_mem_re",   32'(bus.MEM_RE),   32'd1);
    check("s1_mem_addr", 32'(bus.MEM_ADDR), 32'd5);
    check("s1_busy",     32'(BUSY),         32'd1);
    check("s1_arready",  32'(bus.ARREADY),  32'd0);
    check("s1_rvalid_early", 32'(bus.RVALID), 32'd0);
    bus.MEM_RVALID = 1'b1;
    bus.MEM_RDATA  = mem[5];
    tick();
    bus.MEM_RVALID = 1'b0;
    bus.MEM_RDATA  = '0;
    check("s1_rvalid", 32'(bus.RVALID), 32'd1);
    check("s1_rdata",  bus.RDATA,       32'hDEADBEEF);
    check("s1_rresp",  32'(bus.RRESP),  32'd0);
    check("s1_mem_re_off", 32'(bus.MEM_RE), 32'd0);
    tick();
    check("s1_rvalid_done", 32'(bus.RVALID), 32'd0);
    check("s1_arready_done", 32'(bus.ARREADY), 32'd1);
    check("s1_re_pulses", 32'(re_count - re_before), 32'd1);

    // Scenario 2: decode error
    re_before = re_count;
    ar_issue(10'd1023);
    check("s2_rvalid",  32'(bus.RVALID),  32'd1);
    check("s2_rresp",   32'(bus.RRESP),   32'd3);
    check("s2_rdata",   bus.RDATA,        32'd0);
    check("s2_mem_re",  32'(bus.MEM_RE),  32'd0);
    check("s2_arready", 32'(bus.ARREADY), 32'd0);
    tick();
    check("s2_rvalid_done",  32'(bus.RVALID),  32'd0);
    check("s2_arready_done", 32'(bus.ARREADY), 32'd1);
    check("s2_re_pulses", 32'(re_count - re_before), 32'd0);

    // Scenario 3: timeout, late response ignored, then a good read
    ar_issue(10'd3);
    repeat (15) tick();
    check("s3_rvalid_c16", 32'(bus.RVALID),   32'd0);
    check("s3_mem_addr",   32'(bus.MEM_ADDR), 32'd3);
    check("s3_busy",       32'(BUSY),         32'd1);
    tick();
    check("s3_rvalid", 32'(bus.RVALID), 32'd1);
    check("s3_rresp",  32'(bus.RRESP),  32'd2);
    check("s3_rdata",  bus.RDATA,       32'd0);
    bus.MEM_RVALID = 1'b1;
    bus.MEM_RDATA  = 32'hFFFFFFFF;
    tick();
    check("s3_rvalid_done",  32'(bus.RVALID),  32'd0);
    check("s3_arready_done", 32'(bus.ARREADY), 32'd1);
    tick();
    check("s3_late_busy",   32'(BUSY),       32'd0);
    check("s3_late_rvalid", 32'(bus.RVALID), 32'd0);
    bus.MEM_RVALID = 1'b0;
    ar_issue(10'd3);
    tick();
    bus.MEM_RVALID = 1'b1;
    bus.MEM_RDATA  = mem[3];
    tick();
    bus.MEM_RVALID = 1'b0;
    check("s3_next_rvalid", 32'(bus.RVALID), 32'd1);
    check("s3_next_rdata",  bus.RDATA,       32'h0BADF00D);
    check("s3_next_rresp",  32'(bus.RRESP),  32'd0);
    tick();

    // Scenario 4: R back-pressure
    bus.RREADY = 1'b0;
    ar_issue(10'd7);
    bus.MEM_RVALID = 1'b1;
    bus.MEM_RDATA  = mem[7];
    tick();
    bus.MEM_RVALID = 1'b0;
    bus.MEM_RDATA  = 32'hFFFF0000;
    for (int i = 0; i < 5; i++) begin
      check("s4_hold_rvalid",  32'(bus.RVALID),  32'd1);
      check("s4_hold_rdata",   bus.RDATA,        32'h12345678);
      check("s4_hold_rresp",   32'(bus.RRESP),   32'd0);
      check("s4_hold_arready", 32'(bus.ARREADY), 32'd0);
      tick();
    end
    bus.RREADY = 1'b1;
    check("s4_rvalid_pre", 32'(bus.RVALID), 32'd1);
    tick();
    check("s4_rvalid_done",  32'(bus.RVALID),  32'd0);
    check("s4_arready_done", 32'(bus.ARREADY), 32'd1);

    // Scenario 5: reset pulse mid-MEMRD
    ar_issue(10'd9);
    tick();
    tick();
    check("s5_busy_pre", 32'(BUSY), 32'd1);
    #2 ARESETn = 1'b0;
    #1;
    check("s5_arready",  32'(bus.ARREADY),  32'd0);
    check("s5_rvalid",   32'(bus.RVALID),   32'd0);
    check("s5_busy",     32'(BUSY),         32'd0);
    check("s5_mem_addr", 32'(bus.MEM_ADDR), 32'd0);
    check("s5_rdata",    bus.RDATA,         32'd0);
    check("s5_rresp",    32'(bus.RRESP),    32'd0);
    bus.MEM_RVALID = 1'b1;
    bus.MEM_RDATA  = 32'h77777777;
    tick();
    tick();
    #2 ARESETn = 1'b1;
    tick();
    check("s5_rel_arready", 32'(bus.ARREADY), 32'd1);
    check("s5_rel_rvalid",  32'(bus.RVALID),  32'd0);
    check("s5_rel_busy",    32'(BUSY),        32'd0);
    bus.MEM_RVALID = 1'b0;
    seen_rvalid = 1'b0;
    repeat (20) begin
      tick();
      if (bus.RVALID) seen_rvalid = 1'b1;
    end
    check("s5_no_rvalid", 32'(seen_rvalid), 32'd0);

    // Scenario 6: data on the final wait cycle wins
    ar_issue(10'd11);
    repeat (15) tick();
    check("s6_rvalid_c16", 32'(bus.RVALID), 32'd0);
    bus.MEM_RVALID = 1'b1;
    bus.MEM_RDATA  = 32'hA5A5A5A5;
    tick();
    bus.MEM_RVALID = 1'b0;
    check("s6_rvalid", 32'(bus.RVALID), 32'd1);
    check("s6_rresp",  32'(bus.RRESP),  32'd0);
    check("s6_rdata",  bus.RDATA,       32'hA5A5A5A5);
    tick();
    check("s6_arready_done", 32'(bus.ARREADY), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_read_responder.md
AXI_READ_RESPONDER -- requirements
Module: axi_read_responder

Interface
REQ-001 Parameter LEN_ADDR, default 10, SHALL set the word-address width of ARADDR and MEM_ADDR.
REQ-002 Parameter LEN_DATA, default 32, SHALL set the data width of RDATA and MEM_RDATA.
REQ-003 Parameter MEM_WORDS, default 1024, SHALL set the number of implemented words; valid addresses are 0..MEM_WORDS-1.
REQ-004 Parameter TIMEOUT, default 16, SHALL set the maximum number of cycles the block waits for a memory response.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 ACLK  in  1  clock; all state updates on the rising edge.
REQ-007 ARESETn  in  1  asynchronous active-low reset.
REQ-008 ARVALID  in  1  read-address valid from the master.
REQ-009 ARREADY  out  1  read-address ready.
REQ-010 ARADDR  in  LEN_ADDR  read word address.
REQ-011 RVALID  out  1  read-data valid.
REQ-012 RREADY  in  1  read-data ready from the master.
REQ-013 RDATA  out  LEN_DATA  read data.
REQ-014 RRESP  out  2  response: 2'b00 OKAY, 2'b10 SLVERR, 2'b11 DECERR.
REQ-015 MEM_RE  out  1  single-cycle memory read strobe.
REQ-016 MEM_ADDR  out  LEN_ADDR  memory read address.
REQ-017 MEM_RDATA  in  LEN_DATA  memory read data.
REQ-018 MEM_RVALID  in  1  MEM_RDATA is valid this cycle.
REQ-019 BUSY  out  1  high whenever the state is not IDLE.

Function
REQ-020 The FSM SHALL have the states IDLE, MEMRD and RESP.
REQ-021 ARREADY SHALL be high only in IDLE; an AR handshake occurs on a rising edge with ARVALID=1 and ARREADY=1, and ARADDR is captured on that edge.
REQ-022 For a handshake with ARADDR < MEM_WORDS, the FSM SHALL go IDLE->MEMRD, and MEM_RE SHALL be high for exactly the first MEMRD cycle.
REQ-023 MEM_ADDR SHALL equal the captured address and stay stable for all of MEMRD.
REQ-024 For a handshake with ARADDR >= MEM_WORDS, the FSM SHALL go IDLE->RESP with RRESP=DECERR and RDATA=0, and MEM_RE SHALL stay low.
REQ-025 In MEMRD, the first edge with MEM_RVALID=1 SHALL register MEM_RDATA into RDATA, set RRESP=OKAY, and move the FSM to RESP.
REQ-026 A 5-bit-or-wider wait counter SHALL clear on entry to MEMRD and increment each MEMRD cycle.
REQ-027 If the wait counter reaches TIMEOUT with no MEM_RVALID, the FSM SHALL go to RESP with RRESP=SLVERR and RDATA=0.
REQ-028 If MEM_RVALID=1 on the timeout cycle, the data SHALL win and the response SHALL be OKAY.
REQ-029 MEM_RVALID outside MEMRD SHALL be ignored, including a late response after a timeout.
REQ-030 In RESP, RVALID SHALL be 1 and SHALL NOT depend combinationally on RREADY.
REQ-031 RDATA and RRESP SHALL stay stable while RVALID=1 and RREADY=0.
REQ-032 On an edge with RVALID=1 and RREADY=1, the FSM SHALL return to IDLE.
REQ-033 With MEM_RVALID in the MEM_RE cycle, RVALID SHALL rise 2 cycles after the AR handshake edge.
REQ-034 A DECERR response SHALL raise RVALID 1 cycle after the AR handshake edge.
REQ-035 ARREADY SHALL be high in the cycle after an R handshake, so a back-to-back read needs at least 3 cycles per in-range transaction.

Reset
REQ-036 While ARESETn=0: ARREADY=0, RVALID=0, MEM_RE=0, BUSY=0, RDATA=0, RRESP=2'b00, MEM_ADDR=0, wait counter=0, state=IDLE.
REQ-037 Reset assertion SHALL take effect immediately, without waiting for ACLK.
REQ-038 Reset in mid-transaction SHALL abandon the transaction, and no R beat for it SHALL be issued after reset.
REQ-039 ARREADY SHALL rise in the first cycle after ARESETn deasserts.

Structure
REQ-040 The RRESP codes (OKAY, SLVERR, DECERR) and the state enum state_t {IDLE, MEMRD, RESP} SHALL live in a shared package axi_pkg alongside hook_t.
REQ-041 The R-channel output register (RVALID/RDATA/RRESP hold until RREADY) SHALL be a sub-module r_rsp_reg, reusable by the write-response path.
REQ-042 The implementation SHALL be 120-400 lines of RTL, with no latches and all combinational outputs fully assigned.

Verification
REQ-043 Scenario 1: preload mem[5]=32'hDEADBEEF, ARADDR=5, memory latency 0, RREADY=1 -> RVALID 2 cycles after AR, RDATA=32'hDEADBEEF, RRESP=00, one MEM_RE pulse.
REQ-044 Scenario 2: ARADDR=1023 with MEM_WORDS=1000 -> RVALID next cycle, RRESP=11, RDATA=0, MEM_RE never high.
REQ-045 Scenario 3: MEM_RVALID withheld -> after 16 MEMRD cycles RRESP=10, RDATA=0; a late MEM_RVALID is ignored and the next read returns correct data.
REQ-046 Scenario 4: mem[7]=32'h12345678 with RREADY low for 5 cycles -> RVALID, RDATA and RRESP stable throughout, ARREADY=0, handshake on RREADY, ARREADY=1 the next cycle.
REQ-047 Scenario 5: ARESETn pulsed low mid-MEMRD -> all outputs reset at once, no RVALID afterwards, ARREADY=1 the first cycle after release.
REQ-048 Scenario 6: MEM_RVALID exactly on the 16th MEMRD cycle with data 32'hA5A5A5A5 -> RRESP=00, RDATA=32'hA5A5A5A5.
